// File: rtl/idiv_sequential.sv
// Sequential unsigned divider: restoring shift-subtract, one quotient bit per clock.
// Start/done handshake; published results stay put until the next completion.
module idiv_sequential #(
    parameter int SIZE = 4
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            iStart,
    input  logic [SIZE-1:0] iDividend,
    input  logic [SIZE-1:0] iDivisor,
    output logic [SIZE-1:0] oQuotient,
    output logic [SIZE-1:0] oRemainder,
    output logic            oDone,
    output logic            oBusy,
    output logic            oDivByZero
);

    localparam int CW = $clog2(SIZE + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [SIZE-1:0] r_divisor;
    logic [SIZE-1:0] w_divisor_next;
    logic [SIZE-1:0] r_quo;
    logic [SIZE-1:0] w_quo_next;
    logic [SIZE-1:0] r_rem;
    logic [SIZE-1:0] w_rem_next;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_next;
    logic [SIZE-1:0] w_oquo_next;
    logic [SIZE-1:0] w_orem_next;
    logic            w_done_next;
    logic            w_busy_next;
    logic            w_dz_next;

    // The partial remainder is SIZE+1 bits only during the trial subtraction;
    // after restoring it is always below the divisor, so SIZE bits are stored.
    logic [SIZE:0]   w_shift;
    logic [SIZE:0]   w_trial;
    logic            w_qbit;
    logic [SIZE-1:0] w_rem_step;
    logic [SIZE-1:0] w_quo_step;

    assign w_shift    = {r_rem, r_quo[SIZE-1]};
    assign w_trial    = w_shift - {1'b0, r_divisor};
    assign w_qbit     = ~w_trial[SIZE];
    assign w_rem_step = w_qbit ? w_trial[SIZE-1:0] : w_shift[SIZE-1:0];
    assign w_quo_step = {r_quo[SIZE-2:0], w_qbit};

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_divisor  <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_count    <= '0;
            oQuotient  <= '0;
            oRemainder <= '0;
            oDone      <= 1'b0;
            oBusy      <= 1'b0;
            oDivByZero <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_divisor  <= w_divisor_next;
            r_quo      <= w_quo_next;
            r_rem      <= w_rem_next;
            r_count    <= w_count_next;
            oQuotient  <= w_oquo_next;
            oRemainder <= w_orem_next;
            oDone      <= w_done_next;
            oBusy      <= w_busy_next;
            oDivByZero <= w_dz_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_divisor_next = r_divisor;
        w_quo_next     = r_quo;
        w_rem_next     = r_rem;
        w_count_next   = r_count;
        w_oquo_next    = oQuotient;
        w_orem_next    = oRemainder;
        w_done_next    = 1'b0;
        w_busy_next    = oBusy;
        w_dz_next      = oDivByZero;

        case (r_state)
            IDLE: begin
                if (iStart) begin
                    if (iDivisor != '0) begin
                        w_divisor_next = iDivisor;
                        w_quo_next     = iDividend;
                        w_rem_next     = '0;
                        w_count_next   = '0;
                        w_busy_next    = 1'b1;
                        w_dz_next      = 1'b0;
                        w_state_next   = RUN;
                    end else begin
                        // Divide by zero completes immediately with a defined result.
                        w_oquo_next = '1;
                        w_orem_next = iDividend;
                        w_dz_next   = 1'b1;
                        w_done_next = 1'b1;
                    end
                end
            end
            RUN: begin
                w_quo_next   = w_quo_step;
                w_rem_next   = w_rem_step;
                w_count_next = r_count + CW'(1);
                if (r_count == CW'(SIZE - 1)) begin
                    w_oquo_next  = w_quo_step;
                    w_orem_next  = w_rem_step;
                    w_done_next  = 1'b1;
                    w_busy_next  = 1'b0;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_idiv_sequential.sv
// Self-checking bench for idiv_sequential: vector table, corner sequences and
// an exhaustive sweep, all checked through a scoreboard of expected results.
module tb_idiv_sequential;

    localparam int SIZE = 4;

    logic            Clock;
    logic            Reset;
    logic            iStart;
    logic [SIZE-1:0] iDividend;
    logic [SIZE-1:0] iDivisor;
    logic [SIZE-1:0] oQuotient;
    logic [SIZE-1:0] oRemainder;
    logic            oDone;
    logic            oBusy;
    logic            oDivByZero;

    idiv_sequential #(.SIZE(SIZE)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .iStart     (iStart),
        .iDividend  (iDividend),
        .iDivisor   (iDivisor),
        .oQuotient  (oQuotient),
        .oRemainder (oRemainder),
        .oDone      (oDone),
        .oBusy      (oBusy),
        .oDivByZero (oDivByZero)
    );

    typedef struct {
        logic [SIZE-1:0] q;
        logic [SIZE-1:0] r;
        logic            dz;
        int              due;
    } exp_t;

    typedef struct {
        logic [SIZE-1:0] a;
        logic [SIZE-1:0] b;
        logic [SIZE-1:0] q;
        logic [SIZE-1:0] r;
        logic            dz;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[11];
    int   cycle  = 0;
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;
    always @(posedge Clock) cycle++;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d (cycle %0d)", name, got, want, cycle);
        end
    endtask

    // Completion monitor: every oDone must match the oldest expected result.
    always @(negedge Clock) begin
        if (!Reset && oDone) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done q=%0d r=%0d dz=%0d cycle %0d",
                         oQuotient, oRemainder, oDivByZero, cycle);
            end else begin
                mon_e = sb.pop_front();
                txn++;
                $display("txn %0d: q=%0d r=%0d dz=%0d (want q=%0d r=%0d dz=%0d) cycle %0d",
                         txn, oQuotient, oRemainder, oDivByZero,
                         mon_e.q, mon_e.r, mon_e.dz, cycle);
                chk("quotient",   int'(oQuotient),  int'(mon_e.q));
                chk("remainder",  int'(oRemainder), int'(mon_e.r));
                chk("divbyzero",  int'(oDivByZero), int'(mon_e.dz));
                chk("latency",    cycle,            mon_e.due);
                chk("busy_at_done", int'(oBusy),    0);
            end
        end
    end

    // Called #1 after a clock edge; the request is sampled on the next edge.
    task automatic start(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                         input logic [SIZE-1:0] eq, input logic [SIZE-1:0] er,
                         input logic edz);
        exp_t e;
        iStart    = 1'b1;
        iDividend = a;
        iDivisor  = b;
        e.q   = eq;
        e.r   = er;
        e.dz  = edz;
        e.due = cycle + 1 + ((b == '0) ? 0 : SIZE);
        sb.push_back(e);
        @(posedge Clock); #1;
        iStart = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            @(posedge Clock); #1;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL done_timeout pending %0d cycle %0d", sb.size(), cycle);
            sb.delete();
        end
        @(posedge Clock); #1;
    endtask

    initial begin
        vecs[0]  = '{4'd13, 4'd3,  4'd4,  4'd1, 1'b0};
        vecs[1]  = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0};
        vecs[2]  = '{4'd5,  4'd7,  4'd0,  4'd5, 1'b0};
        vecs[3]  = '{4'd9,  4'd0,  4'd15, 4'd9, 1'b1};
        vecs[4]  = '{4'd8,  4'd2,  4'd4,  4'd0, 1'b0};
        vecs[5]  = '{4'd14, 4'd3,  4'd4,  4'd2, 1'b0};
        vecs[6]  = '{4'd7,  4'd2,  4'd3,  4'd1, 1'b0};
        vecs[7]  = '{4'd0,  4'd5,  4'd0,  4'd0, 1'b0};
        vecs[8]  = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0};
        vecs[9]  = '{4'd1,  4'd15, 4'd0,  4'd1, 1'b0};
        vecs[10] = '{4'd0,  4'd0,  4'd15, 4'd0, 1'b1};

        Reset = 1'b1; iStart = 1'b0; iDividend = '0; iDivisor = '0;
        repeat (3) @(posedge Clock);
        #1;
        Reset = 1'b0;
        chk("rst_quotient",  int'(oQuotient),  0);
        chk("rst_remainder", int'(oRemainder), 0);
        chk("rst_done",      int'(oDone),      0);
        chk("rst_busy",      int'(oBusy),      0);
        chk("rst_divbyzero", int'(oDivByZero), 0);

        // 13/3: busy for exactly SIZE cycles after the start edge.
        start(4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
        for (int i = 0; i < SIZE; i++) begin
            chk("busy_run_13_3", int'(oBusy), 1);
            @(posedge Clock); #1;
        end
        chk("busy_clear_13_3", int'(oBusy), 0);
        chk("done_13_3", int'(oDone), 1);
        wait_idle();

        for (int i = 0; i < 11; i++) begin
            start(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz);
            wait_idle();
        end

        // Back-to-back: second request issued during the first's oDone cycle.
        start(4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
        for (int i = 0; i < 20 && !oDone; i++) begin
            @(posedge Clock); #1;
        end
        chk("b2b_first_done", int'(oDone), 1);
        start(4'd5, 4'd7, 4'd0, 4'd5, 1'b0);
        chk("b2b_done_pulse", int'(oDone), 0);
        chk("b2b_accepted",   int'(oBusy), 1);
        chk("b2b_held_q",     int'(oQuotient), 15);
        wait_idle();

        // Divide by zero, then a normal division clears the flag on acceptance.
        start(4'd9, 4'd0, 4'd15, 4'd9, 1'b1);
        chk("dz_busy",      int'(oBusy),      0);
        chk("dz_flag",      int'(oDivByZero), 1);
        @(posedge Clock); #1;
        chk("dz_done_pulse", int'(oDone), 0);
        chk("dz_busy_after", int'(oBusy), 0);
        wait_idle();
        start(4'd8, 4'd2, 4'd4, 4'd0, 1'b0);
        chk("dz_cleared", int'(oDivByZero), 0);
        wait_idle();

        // Start while busy is ignored; port changes during RUN have no effect.
        start(4'd14, 4'd3, 4'd4, 4'd2, 1'b0);
        iStart = 1'b1; iDividend = 4'd1; iDivisor = 4'd1;
        @(posedge Clock); #1;
        iStart = 1'b0; iDividend = 4'd0; iDivisor = 4'd0;
        wait_idle();

        // Reset mid-run aborts without a completion.
        start(4'd12, 4'd5, 4'd2, 4'd2, 1'b0);
        @(posedge Clock); #1;
        Reset = 1'b1;
        @(posedge Clock); #1;
        sb.delete();
        chk("abort_quotient",  int'(oQuotient),  0);
        chk("abort_remainder", int'(oRemainder), 0);
        chk("abort_busy",      int'(oBusy),      0);
        chk("abort_done",      int'(oDone),      0);
        chk("abort_divbyzero", int'(oDivByZero), 0);
        Reset = 1'b0;
        repeat (8) @(posedge Clock);
        #1;
        start(4'd7, 4'd2, 4'd3, 4'd1, 1'b0);
        wait_idle();

        // Exhaustive sweep against a behavioural reference.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                logic [SIZE-1:0] ea, eb, eq, er;
                ea = SIZE'(a);
                eb = SIZE'(b);
                eq = (b == 0) ? '1 : SIZE'(a / b);
                er = (b == 0) ? ea : SIZE'(a % b);
                start(ea, eb, eq, er, (b == 0));
                wait_idle();
            end
        end

        repeat (2) @(posedge Clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/idiv_sequential.md
Name: idiv_sequential

Overview:
- Sequential unsigned integer divider, the inverse of the team's IMUL_4bits multiplier.
- Computes quotient and remainder by restoring shift-subtract, one quotient bit per clock.
- Start/done handshake.
- Built from the same collateral primitives (up-counter, enabled flops) and sits beside the multiplier in the arithmetic datapath.

Parameters:
- SIZE, 4, operand width in bits for dividend, divisor, quotient and remainder (valid range 2..16).

Ports:
- Clock  input  1  system clock; all state changes on posedge.
- Reset  input  1  synchronous, active-high reset.
- iStart  input  1  request; sampled only in IDLE.
- iDividend  input  SIZE  unsigned dividend; sampled with iStart.
- iDivisor  input  SIZE  unsigned divisor; sampled with iStart.
- oQuotient  output  SIZE  result quotient; held until next completion.
- oRemainder  output  SIZE  result remainder; held until next completion.
- oDone  output  1  one-cycle pulse; results valid.
- oBusy  output  1  high while a division is in progress.
- oDivByZero  output  1  set with a result whose divisor was 0.

Behaviour:
- Reset is synchronous, active-high on Clock. It overrides everything, including mid-operation.
- Reset values: state=IDLE, oQuotient=0, oRemainder=0, oDone=0, oBusy=0, oDivByZero=0, iteration counter=0.
- States:
  - IDLE: waiting for iStart.
  - RUN: iterating.
  - No separate DONE state; oDone is a registered pulse.
- IDLE, iStart=1, divisor≠0, at edge T:
  - Latch divisor D.
  - Load quotient shift register Q=dividend and partial remainder R (SIZE+1 bits)=0.
  - Counter=0, oBusy=1, oDivByZero=0; go to RUN.
- IDLE, iStart=1, divisor=0, at edge T:
  - No RUN. oQuotient=all ones, oRemainder=dividend, oDivByZero=1, oDone=1 for one cycle; oBusy stays 0.
- RUN, each edge:
  - Shift {R,Q} left by 1.
  - trial = R − {0,D} in SIZE+1 bits.
  - If trial MSB is 0: R=trial and Q[0]=1; else R unchanged and Q[0]=0.
  - Counter increments.
- Completion on the edge performing the SIZE-th iteration (edge T+SIZE):
  - oQuotient=Q, oRemainder=R[SIZE-1:0].
  - oDone=1 for exactly one cycle, oBusy=0, state=IDLE.
- Latency: start sampled at edge T, results and oDone visible in the cycle after edge T+SIZE. Throughput: one division per SIZE+1 cycles at most.
- oDone deasserts on the next edge unconditionally.
- iStart while oBusy=1: ignored. Operands are not resampled and the operation in flight is unaffected.
- iStart high in the same cycle oDone=1 (state IDLE): accepted as a new operation. The new run does not disturb the just-published results until its own completion; oDivByZero clears at acceptance.
- Outputs oQuotient/oRemainder/oDivByZero hold their last values indefinitely while IDLE.
- Reset asserted during RUN: the operation is aborted. Outputs go to reset values on that edge and no oDone is issued.
- Arithmetic invariants on completion: dividend = quotient·divisor + remainder, with remainder < divisor. The remainder never needs SIZE+1 bits at the output.
- Operands changing on the input ports during RUN have no effect.

Test Plan:
- Reset, then iDividend=13, iDivisor=3, iStart pulse at edge T -> oBusy=1 for 4 cycles; oDone pulse after edge T+4 with oQuotient=4, oRemainder=1, oDivByZero=0.
- 15/1 then 5/7 back-to-back, second iStart asserted during first's oDone cycle -> first result Q=15 R=0; second accepted immediately, result Q=0 R=5 after 4 more edges.
- 9/0 -> oDone one cycle after start, oQuotient=15, oRemainder=9, oDivByZero=1, oBusy never high. Next 8/2 -> oDivByZero clears on acceptance, result Q=4 R=0.
- Start 14/3, pulse iStart again at cycle 2 with operands 1/1, and change input ports -> second iStart ignored; result Q=4 R=2.
- Start 12/5, assert Reset at cycle 2 of RUN -> all outputs 0 on that edge, no oDone. A following 7/2 yields Q=3 R=1 normally.
- Exhaustive sweep for SIZE=4, all 256 dividend/divisor pairs -> every result matches the reference model (divisor 0 per rule above), oDone latency exactly 4 edges for nonzero divisors.
